// File: rtl/keypad_entry_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : keypad_entry_ctrl
// Purpose  : Sequences a 4-digit HHMM keypad entry, validates it and commits it
//            to the time or alarm register with a one-cycle load strobe.
// Revision : 1.0 - initial release
//==============================================================================
module keypad_entry_ctrl #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        set_time_btn,
    input  logic        set_alarm_btn,
    input  logic        cancel_btn,
    input  logic [15:0] keypad_values,
    input  logic        shift_pulse,
    output logic        keypad_reset_shift,
    output logic        load_time,
    output logic        load_alarm,
    output logic [15:0] entry_value,
    output logic        entry_active,
    output logic [2:0]  digit_count,
    output logic        error
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_COLLECT = 3'd2,
        S_CHECK   = 3'd3,
        S_COMMIT  = 3'd4,
        S_ERROR   = 3'd5,
        S_ABORT   = 3'd6
    } state_t;

    localparam logic [15:0] c_TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    logic        r_set_time_q;
    logic        r_set_alarm_q;
    logic        r_cancel_q;
    logic        r_target_alarm;
    logic [15:0] r_timer;
    logic        r_reset_shift;
    logic        r_load_time;
    logic        r_load_alarm;
    logic [15:0] r_entry_value;
    logic        r_entry_active;
    logic [2:0]  r_digit_count;
    logic        r_error;

    logic        w_time_edge;
    logic        w_alarm_edge;
    logic        w_cancel_edge;
    logic        w_value_ok;

    assign w_time_edge   = set_time_btn  & ~r_set_time_q;
    assign w_alarm_edge  = set_alarm_btn & ~r_set_alarm_q;
    assign w_cancel_edge = cancel_btn    & ~r_cancel_q;

    // HH in 00..23 and MM in 00..59, each digit a legal BCD value
    assign w_value_ok = (keypad_values[15:12] <= 4'd2) &&
                        (keypad_values[11:8]  <= 4'd9) &&
                        ((keypad_values[15:12] != 4'd2) || (keypad_values[11:8] <= 4'd3)) &&
                        (keypad_values[7:4]   <= 4'd5) &&
                        (keypad_values[3:0]   <= 4'd9);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_set_time_q   <= 1'b0;
            r_set_alarm_q  <= 1'b0;
            r_cancel_q     <= 1'b0;
            r_target_alarm <= 1'b0;
            r_timer        <= 16'd0;
            r_reset_shift  <= 1'b0;
            r_load_time    <= 1'b0;
            r_load_alarm   <= 1'b0;
            r_entry_value  <= 16'h0000;
            r_entry_active <= 1'b0;
            r_digit_count  <= 3'd0;
            r_error        <= 1'b0;
        end else begin
            r_set_time_q  <= set_time_btn;
            r_set_alarm_q <= set_alarm_btn;
            r_cancel_q    <= cancel_btn;
            r_reset_shift <= 1'b0;
            r_load_time   <= 1'b0;
            r_load_alarm  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_time_edge || w_alarm_edge) begin
                        r_target_alarm <= ~w_time_edge;
                        r_error        <= 1'b0;
                        r_reset_shift  <= 1'b1;
                        r_entry_active <= 1'b1;
                        r_state        <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    r_digit_count <= 3'd0;
                    r_timer       <= 16'd0;
                    r_state       <= S_COLLECT;
                end
                S_COLLECT: begin
                    // r_timer counts cycles since the last digit; a digit
                    // cycle itself counts as the first idle cycle elapsed
                    if (w_cancel_edge) begin
                        r_reset_shift  <= 1'b1;
                        r_entry_active <= 1'b0;
                        r_state        <= S_ABORT;
                    end else if (shift_pulse) begin
                        r_digit_count <= r_digit_count + 3'd1;
                        r_timer       <= 16'd1;
                        if (r_digit_count == 3'd3) begin
                            r_state <= S_CHECK;
                        end
                    end else if (r_timer == c_TIMEOUT_LAST) begin
                        r_error        <= 1'b1;
                        r_reset_shift  <= 1'b1;
                        r_entry_active <= 1'b0;
                        r_state        <= S_ABORT;
                    end else begin
                        r_timer <= r_timer + 16'd1;
                    end
                end
                S_CHECK: begin
                    r_entry_active <= 1'b0;
                    r_reset_shift  <= 1'b1;
                    if (w_value_ok) begin
                        r_entry_value <= keypad_values;
                        r_load_time   <= ~r_target_alarm;
                        r_load_alarm  <= r_target_alarm;
                        r_state       <= S_COMMIT;
                    end else begin
                        r_error <= 1'b1;
                        r_state <= S_ERROR;
                    end
                end
                S_COMMIT, S_ERROR, S_ABORT: begin
                    r_digit_count <= 3'd0;
                    r_state       <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign keypad_reset_shift = r_reset_shift;
    assign load_time          = r_load_time;
    assign load_alarm         = r_load_alarm;
    assign entry_value        = r_entry_value;
    assign entry_active       = r_entry_active;
    assign digit_count        = r_digit_count;
    assign error              = r_error;

endmodule
`default_nettype wire

// File: doc/keypad_entry_ctrl.md
# keypad_entry_ctrl

Sequencer for the alarm clock's 4-digit keypad shift register: on a set-time or set-alarm request it clears the keypad, counts four digit entries via the keypad's shift pulse, and validates the HHMM value. A valid value is committed to the clock or alarm register with a one-cycle load strobe. It sits between the front-panel mode buttons, the `keypad` block (driving its reset-shift input, consuming its values and shift pulse) and the time/alarm registers.

## Interface
- `TIMEOUT_CYCLES`, default 1000: cycles without a digit in COLLECT before the entry aborts; legal range 2..65535.
- `clk` in 1: single clock. All logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `set_time_btn` in 1: level input, edge-detected internally.
- `set_alarm_btn` in 1: level input, edge-detected internally.
- `cancel_btn` in 1: level input, edge-detected internally.
- `keypad_values` in 16: four BCD digits from the keypad, `[15:12]` oldest, `[3:0]` newest.
- `shift_pulse` in 1: one-cycle pulse from the keypad, one per digit shifted in.
- `keypad_reset_shift` out 1: clears the keypad shift register.
- `load_time` out 1: one-cycle commit strobe to the time register.
- `load_alarm` out 1: one-cycle commit strobe to the alarm register.
- `entry_value` out 16: last committed HHMM in BCD.
- `entry_active` out 1: high in CLEAR, COLLECT and CHECK.
- `digit_count` out 3: digits received in the current entry, 0..4.
- `error` out 1: sticky flag for the last invalid or timed-out entry.

## Operation
- **Edge detection:** register each button once. edge = btn & ~btn_q, evaluated in the cycle the level first reads high.
- **Outputs:** all outputs are registered. Reset values are all 0, `entry_value` = 16'h0000, state IDLE, target = time.
- **IDLE**
  - On a set_time or set_alarm edge: latch the target, go to CLEAR and clear `error`.
  - Both edges in the same cycle: time wins.
  - `shift_pulse` and cancel are ignored in IDLE.
- **CLEAR:** `keypad_reset_shift`=1 for exactly one cycle. `digit_count`←0, timeout counter←0, then go to COLLECT.
- **COLLECT**
  - Each `shift_pulse` increments `digit_count` and zeroes the timeout counter.
  - On the 4th pulse, go to CHECK.
  - Mode-button edges are ignored.
  - A cancel edge, or the timeout counter reaching TIMEOUT_CYCLES−1, goes to ABORT. Timeout also sets `error`.
  - Priority in the same cycle: cancel > 4th shift_pulse > timeout.
- **CHECK:** samples `keypad_values`, one cycle after the 4th pulse. The value is valid iff all of:
  - H tens ≤ 2
  - H ones ≤ 9, and ≤ 3 when H tens = 2
  - M tens ≤ 5
  - M ones ≤ 9
  
  Valid: latch into `entry_value`, go to COMMIT. Invalid: go to ERROR.
- **COMMIT:** for one cycle, `load_time` or `load_alarm` (per target) =1 and `keypad_reset_shift`=1. Then IDLE, `digit_count`←0.
- **ERROR:** `error`←1, `keypad_reset_shift`=1 for one cycle, `entry_value` unchanged. Then IDLE.
- **ABORT:** `keypad_reset_shift`=1 for one cycle, no load strobe. Then IDLE.
- `shift_pulse` in CHECK, COMMIT, ERROR or ABORT is ignored, and `digit_count` saturates at 4.
- `reset` mid-entry returns to IDLE with all outputs at their reset values. No load strobe is emitted.

## Timing
- Button edge at cycle N: state CLEAR and `keypad_reset_shift`=1 in N+1, COLLECT in N+2.
- 4th `shift_pulse` at cycle M:
  - `digit_count`=4 and CHECK in M+1.
  - COMMIT (load strobe, reset_shift, new `entry_value`) in M+2, or ERROR with `error`=1 in M+2.
  - IDLE in M+3.
- Cancel edge at cycle C in COLLECT: ABORT and reset_shift=1 in C+1, IDLE in C+2.
- Timeout: last pulse (or COLLECT entry) at cycle T, ABORT at T+TIMEOUT_CYCLES.
- `load_*`, `keypad_reset_shift` and ABORT/ERROR last exactly one cycle; they are never back-to-back for one entry, except CLEAR followed by COLLECT.
- `keypad_values` is required to be settled one cycle after its `shift_pulse`.

## Test plan
- **Valid time entry:** set_time edge, then digits 1,2,3,4 with one pulse each → reset_shift in N+1, `load_time` pulse, `entry_value`=16'h1234, `load_alarm` stays 0, `error`=0.
- **Valid alarm entry at boundary:** set_alarm edge, digits 2,3,5,9 → `load_alarm` pulse, `entry_value`=16'h2359.
- **Invalid entries:** digits 2,4,0,0 and separately 1,2,6,0 → ERROR, `error`=1, no load strobe, `entry_value` keeps its prior value. A new set_time edge clears `error`.
- **Cancel:** set_time, digits 0,7, then cancel → ABORT, reset_shift pulse, `digit_count`→0, no load. Cancel and the 4th pulse in the same cycle → ABORT.
- **Timeout:** TIMEOUT_CYCLES=8, set_time, one digit, then idle 8 cycles → ABORT, `error`=1, no load. A pulse at cycle 7 restarts the count.
- **Simultaneous and reset:** set_time and set_alarm edges together → the commit uses `load_time`. Assert `reset` with `digit_count`=3 → IDLE, all outputs 0, no strobe. An extra pulse during CHECK leaves `digit_count`=4.
